// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter and its result FIFO.
package wb_port_arbiter_pkg;

  // Arbiter FSM encoding; kept as plain constants so legacy code can compare against them.
  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_DRAIN  = 1'b1;

  // Which source owns the write port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_FIFO = 2'd2
  } gnt_src_e;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Small synchronous FIFO holding MDU results until they win the register-file write port.
// It also exposes per-entry valid bits and addresses for the pending-write hazard compare.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic                          full,
  output logic                          empty,
  output logic [CNT_W-1:0]              count,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr
);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Depth is a power of two, so pointer overflow gives the modulo wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_addr[wr_ptr] <= push_addr;
        mem_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
      entry_addr[i]  = mem_addr[i];
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, MDU results queue in
// a FIFO, and a starvation counter forces the queue to drain while the pipeline is stalled.
//   state  | meaning
//   NORMAL | pipeline wins when requesting; FIFO head takes idle cycles; MDU may push
//   DRAIN  | pipeline stalled, MDU blocked, FIFO head popped every cycle until empty
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              pend_hit,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic [0:0]                          state;
  logic [0:0]                          state_nxt;
  logic [STV_W-1:0]                    starve_cnt;
  logic [STV_W-1:0]                    starve_nxt;
  gnt_src_e                            gnt;
  logic [ADDR_W-1:0]                   gnt_addr;
  logic [DATA_W-1:0]                   gnt_data;
  logic                                force_drain;

  logic                                fifo_push;
  logic                                fifo_pop;
  logic [ADDR_W-1:0]                   head_addr;
  logic [DATA_W-1:0]                   head_data;
  logic                                fifo_full;
  logic                                fifo_empty;
  logic [CNT_W-1:0]                    fifo_count;
  logic [FIFO_DEPTH-1:0]               entry_valid;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]   entry_addr;

  wb_result_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (fifo_push),
    .push_addr   (mdu_addr),
    .push_data   (mdu_data),
    .pop         (fifo_pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // No same-cycle pop credit when full keeps mdu_ready off the arbitration path.
  assign mdu_ready   = !fifo_full && (state == ST_NORMAL);
  assign fifo_push   = mdu_valid && mdu_ready;
  assign force_drain = (state == ST_NORMAL) && !fifo_empty &&
                       (starve_cnt == STV_W'(STARVE_MAX));

  always_comb begin
    gnt        = GNT_NONE;
    fifo_pop   = 1'b0;
    pipe_stall = 1'b0;
    starve_nxt = starve_cnt;
    state_nxt  = state;
    if (state == ST_DRAIN) begin
      pipe_stall = 1'b1;
      starve_nxt = '0;
      if (!fifo_empty) begin
        gnt      = GNT_FIFO;
        fifo_pop = 1'b1;
      end
      if (fifo_count <= CNT_W'(1)) begin
        state_nxt = ST_NORMAL;
      end
    end else if (force_drain) begin
      // The forced pop itself may empty the queue; only stay in DRAIN if something is left.
      pipe_stall = 1'b1;
      gnt        = GNT_FIFO;
      fifo_pop   = 1'b1;
      starve_nxt = '0;
      if ((fifo_count > CNT_W'(1)) || fifo_push) begin
        state_nxt = ST_DRAIN;
      end
    end else if (pipe_we) begin
      gnt        = GNT_PIPE;
      starve_nxt = fifo_empty ? '0 : starve_cnt + 1'b1;
    end else if (!fifo_empty) begin
      gnt        = GNT_FIFO;
      fifo_pop   = 1'b1;
      starve_nxt = '0;
    end else begin
      starve_nxt = '0;
    end
  end

  assign gnt_addr = (gnt == GNT_PIPE) ? pipe_addr : head_addr;
  assign gnt_data = (gnt == GNT_PIPE) ? pipe_data : head_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_NORMAL;
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      // r0 writes still consume the grant but never reach the register file.
      rf_we      <= (gnt != GNT_NONE) && (gnt_addr != '0);
      if (gnt != GNT_NONE) begin
        rf_addr <= gnt_addr;
        rf_data <= gnt_data;
      end
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i] &&
          (((rd_addr_a != '0) && (entry_addr[i] == rd_addr_a)) ||
           ((rd_addr_b != '0) && (entry_addr[i] == rd_addr_b)))) begin
        pend_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model plus directed scenarios.
module tb_wb_port_arbiter;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pipe_we = 1'b0;
  logic [ADDR_W-1:0] pipe_addr = '0;
  logic [DATA_W-1:0] pipe_data = '0;
  logic              pipe_stall;
  logic              mdu_valid = 1'b0;
  logic [ADDR_W-1:0] mdu_addr = '0;
  logic [DATA_W-1:0] mdu_data = '0;
  logic              mdu_ready;
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic [ADDR_W-1:0] rd_addr_b = '0;
  logic              pend_hit;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .pend_hit(pend_hit),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the queue of accepted MDU results, starvation count, drain flag.
  ent_t m_q[$];
  int   m_starve = 0;
  bit   m_drain = 0;
  logic              e_ready, e_stall, e_hit;
  logic              e_we = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_data = '0;
  bit   pipe_taken, mdu_taken;

  ent_t pipe_src[$];
  ent_t mdu_src[$];
  logic [ADDR_W-1:0] wr_log[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_starve = 0;
    m_drain  = 0;
    e_we     = 1'b0;
    e_addr   = '0;
    e_data   = '0;
  endfunction

  function automatic void model_comb();
    bit forced = !m_drain && (m_q.size() > 0) && (m_starve == STARVE_MAX);
    e_ready = !m_drain && (m_q.size() < DEPTH);
    e_stall = m_drain || forced;
    e_hit   = 1'b0;
    foreach (m_q[i]) begin
      if ((rd_addr_a != 0 && m_q[i].a == rd_addr_a) || (rd_addr_b != 0 && m_q[i].a == rd_addr_b))
        e_hit = 1'b1;
    end
  endfunction

  function automatic void model_step();
    ent_t g;
    bit   have = 0;
    mdu_taken  = mdu_valid && e_ready;
    pipe_taken = 0;
    if (e_stall) begin
      g = m_q.pop_front();
      have = 1;
      m_starve = 0;
    end else if (pipe_we) begin
      g.a = pipe_addr;
      g.d = pipe_data;
      have = 1;
      pipe_taken = 1;
      m_starve = (m_q.size() > 0) ? m_starve + 1 : 0;
    end else if (m_q.size() > 0) begin
      g = m_q.pop_front();
      have = 1;
      m_starve = 0;
    end else begin
      m_starve = 0;
    end
    if (mdu_taken) begin
      ent_t n;
      n.a = mdu_addr;
      n.d = mdu_data;
      m_q.push_back(n);
    end
    if (e_stall) m_drain = (m_q.size() > 0);
    e_we = have && (g.a != 0);
    if (have) begin
      e_addr = g.a;
      e_data = g.d;
    end
  endfunction

  task automatic drive();
    pipe_we = (pipe_src.size() > 0);
    if (pipe_we) begin
      pipe_addr = pipe_src[0].a;
      pipe_data = pipe_src[0].d;
    end
    mdu_valid = (mdu_src.size() > 0);
    if (mdu_valid) begin
      mdu_addr = mdu_src[0].a;
      mdu_data = mdu_src[0].d;
    end
  endtask

  // Called at a falling edge: drive, check combinational outputs, step, check registered outputs.
  task automatic run_cycle();
    drive();
    #1;
    model_comb();
    chk("mdu_ready", mdu_ready, e_ready);
    chk("pipe_stall", pipe_stall, e_stall);
    chk("pend_hit", pend_hit, e_hit);
    model_step();
    if (pipe_taken) pipe_src.delete(0);
    if (mdu_taken) mdu_src.delete(0);
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_addr", rf_addr, e_addr);
      chk("rf_data", rf_data, e_data);
    end
    if (rf_we) wr_log.push_back(rf_addr);
    @(negedge clk);
  endtask

  task automatic settle(input int max_cycles);
    int k = 0;
    while ((pipe_src.size() > 0 || mdu_src.size() > 0 || m_q.size() > 0 || m_drain) && k < max_cycles) begin
      run_cycle();
      k++;
    end
    if (k >= max_cycles) begin
      n_cmp++;
      n_bad++;
      $display("FAIL settle_timeout: actual=%0d cycles required=<%0d", k, max_cycles);
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_pipe_stall", pipe_stall, 0);
    chk("rst_mdu_ready", mdu_ready, 1);
    chk("rst_pend_hit", pend_hit, 0);
    model_reset();
    pipe_src.delete();
    mdu_src.delete();
    drive();
    rd_addr_a = '0;
    rd_addr_b = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic ent_t mk(input int a, input logic [DATA_W-1:0] d);
    ent_t e;
    e.a = ADDR_W'(a);
    e.d = d;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_pipe10;
    int n_mdu;
    int exp_ord[3];
    int k;

    #3;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_addr", rf_addr, 0);
    chk("reset_rf_data", rf_data, 0);
    chk("reset_mdu_ready", mdu_ready, 1);
    chk("reset_pipe_stall", pipe_stall, 0);
    chk("reset_pend_hit", pend_hit, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Plain pipeline write.
    pipe_src.push_back(mk(5, 32'h1234));
    drive();
    #1;
    chk("t1_ready", mdu_ready, 1);
    run_cycle();
    chk("t1_rf_we", rf_we, 1);
    chk("t1_rf_addr", rf_addr, 5);
    chk("t1_rf_data", rf_data, 32'h1234);

    // Single MDU result through an idle pipeline, with pend_hit timing.
    rd_addr_a = 5'd7;
    mdu_src.push_back(mk(7, 32'hDEAD));
    drive();
    #1;
    chk("t2_hit_on_push", pend_hit, 0);
    run_cycle();
    drive();
    #1;
    chk("t2_hit_queued", pend_hit, 1);
    run_cycle();
    chk("t2_rf_we", rf_we, 1);
    chk("t2_rf_addr", rf_addr, 7);
    chk("t2_rf_data", rf_data, 32'hDEAD);
    chk("t2_hit_after_pop", pend_hit, 0);
    rd_addr_a = '0;

    // Starvation: continuous pipeline with one queued MDU result.
    wr_log.delete();
    for (int i = 0; i < 6; i++) pipe_src.push_back(mk(10, DATA_W'(i)));
    mdu_src.push_back(mk(3, 32'hBEEF));
    run_cycle();
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      chk("t3_pipe_addr", rf_addr, 10);
    end
    drive();
    #1;
    chk("t3_forced_stall", pipe_stall, 1);
    run_cycle();
    chk("t3_mdu_addr", rf_addr, 3);
    chk("t3_mdu_data", rf_data, 32'hBEEF);
    run_cycle();
    chk("t3_resume_we", rf_we, 1);
    chk("t3_resume_addr", rf_addr, 10);
    settle(40);
    n_pipe10 = 0;
    foreach (wr_log[i]) if (wr_log[i] == 10) n_pipe10++;
    chk("t3_pipe_writes", n_pipe10, 6);

    // Fill the FIFO while the pipeline is busy; third MDU result must wait.
    wr_log.delete();
    for (int i = 0; i < 6; i++) pipe_src.push_back(mk(12, DATA_W'(100 + i)));
    mdu_src.push_back(mk(1, 32'hA1));
    mdu_src.push_back(mk(2, 32'hB2));
    mdu_src.push_back(mk(4, 32'hC4));
    run_cycle();
    run_cycle();
    drive();
    #1;
    chk("t4_ready_full", mdu_ready, 0);
    settle(40);
    exp_ord = '{1, 2, 4};
    n_mdu = 0;
    foreach (wr_log[i]) begin
      if (wr_log[i] != 12) begin
        if (n_mdu < 3) chk("t4_order", wr_log[i], exp_ord[n_mdu]);
        n_mdu++;
      end
    end
    chk("t4_mdu_count", n_mdu, 3);

    // Write to r0 consumes the grant without a register-file write.
    pipe_src.push_back(mk(0, 32'hFFFF));
    run_cycle();
    chk("t5_r0_we", rf_we, 0);

    // Reset while draining.
    for (int i = 0; i < 8; i++) pipe_src.push_back(mk(9, DATA_W'(200 + i)));
    mdu_src.push_back(mk(6, 32'h66));
    mdu_src.push_back(mk(8, 32'h88));
    k = 0;
    while (!m_drain && k < 20) begin
      run_cycle();
      k++;
    end
    chk("t6_reached_drain", pipe_stall, 1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      chk("t6_no_stale_we", rf_we, 0);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if (pipe_src.size() == 0 && $urandom_range(0, 99) < 55)
        pipe_src.push_back(mk(int'($urandom_range(0, 7)), DATA_W'($urandom)));
      if (mdu_src.size() == 0 && $urandom_range(0, 99) < 35)
        mdu_src.push_back(mk(int'($urandom_range(0, 7)), DATA_W'($urandom)));
      rd_addr_a = ADDR_W'($urandom_range(0, 7));
      rd_addr_b = ADDR_W'($urandom_range(0, 7));
      if ($urandom_range(0, 599) == 0) do_reset();
      else run_cycle();
    end
    settle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two sources:
  - the in-order pipeline write-back stage;
  - the multi-cycle mul/div unit (MDU), whose results return asynchronously to the pipeline.
- Buffers MDU results in a small FIFO. The pipeline has priority, and a starvation counter forces a drain that stalls the pipeline.
- Sits between the write-back stage, the MDU and the register file. Also reports pending-write hits to the hazard unit.

Parameters:
- DATA_W, 32, register data width (matches `Rreg_Bus`)
- ADDR_W, 5, register address width (matches `Rreg_AddrBus`)
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- STARVE_MAX, 3, consecutive pipeline-won cycles with a non-empty FIFO before a forced drain

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pipe_we  in  1  write-back stage requests a register write
- pipe_addr  in  ADDR_W  write-back destination register
- pipe_data  in  DATA_W  write-back data (ALU or load result, already selected)
- pipe_stall  out  1  hold write-back stage inputs this cycle (combinational)
- mdu_valid  in  1  MDU result available
- mdu_addr  in  ADDR_W  MDU destination register
- mdu_data  in  DATA_W  MDU result
- mdu_ready  out  1  arbiter accepts an MDU result this cycle (combinational)
- rd_addr_a  in  ADDR_W  decode-stage source register A
- rd_addr_b  in  ADDR_W  decode-stage source register B
- pend_hit  out  1  rd_addr_a or rd_addr_b (non-zero) matches a valid FIFO entry (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_addr  out  ADDR_W  register-file write address (registered)
- rf_data  out  DATA_W  register-file write data (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - rf_we=0, rf_addr=0, rf_data=0
  - FIFO empty, count=0, starve_cnt=0, state=NORMAL
  - After reset: mdu_ready=1, pipe_stall=0, pend_hit=0
- Reset mid-operation discards FIFO contents and any in-flight grant.
- MDU handshake:
  - Push when mdu_valid && mdu_ready.
  - mdu_ready = (count<FIFO_DEPTH) && state==NORMAL. It is not asserted on a same-cycle pop when full.
  - The MDU holds valid/addr/data stable until accepted.
- FSM NORMAL:
  - If pipe_we: grant the pipeline. Register pipe_addr/pipe_data next edge.
    - If the FIFO is non-empty, starve_cnt+=1; else starve_cnt=0.
  - Else if FIFO non-empty: grant the FIFO head (pop), starve_cnt=0.
  - Else: no grant, rf_we=0 next edge.
  - Transition to DRAIN when the FIFO is non-empty and starve_cnt==STARVE_MAX at the start of a cycle. In that cycle:
    - pipe_stall=1 and the FIFO head is granted instead of the pipeline;
    - starve_cnt is cleared;
    - the pipeline request is held by the write-back stage and retried.
- FSM DRAIN:
  - pipe_stall=1 and mdu_ready=0.
  - Pop the head every cycle.
  - Return to NORMAL after the pop that empties the FIFO.
  - Terminates in ≤FIFO_DEPTH cycles.
- Latency: a granted write appears on rf_* exactly one cycle after the grant cycle.
- Address 0: a granted write with addr==0 consumes the grant, but rf_we stays 0 for it.
- Ordering:
  - FIFO entries retire in acceptance order.
  - No address-conflict resolution between the pipeline and FIFO. The hazard unit uses pend_hit to stall readers/writers of pending registers.
- pend_hit: combinational over valid entries only. It includes an entry being popped this cycle until the edge, and excludes an entry being pushed this cycle.
- Simultaneous push and pop with count≥1: count unchanged, pointers both advance. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package/include:
  - FSM state encoding (NORMAL, DRAIN)
  - reuse the existing register-width macros from def.v; no new width constants
- One sub-module is natural: wb_result_fifo. It is a synchronous FIFO with parameterized DATA_W+ADDR_W width and FIFO_DEPTH, full/empty/count outputs, and an entry-valid/address vector for pend_hit compare.
- Arbitration, starvation counter, FSM and output registers stay in the top.

Test Plan:
- Reset then idle, with pipe_we=1, addr=5, data=0x1234 → next cycle rf_we=1, rf_addr=5, rf_data=0x1234. mdu_ready=1 throughout.
- Pipeline idle; MDU pushes addr=7, data=0xDEAD → accepted, pend_hit=1 for rd_addr_a=7. Popped the same cycle (pipe_we=0), so rf_we=1, addr=7 one cycle later and pend_hit drops after the pop edge.
- pipe_we=1 continuously with one MDU entry queued → 3 pipeline writes, then pipe_stall=1 for one cycle and the MDU entry is written. Pipeline writes resume and no pipeline write is lost.
- Fill FIFO (2 entries) with pipe_we=1 → mdu_ready=0 while full. Third MDU result held with valid high until accepted, with no drop or duplicate. Order of rf writes matches push order.
- Pipe write to addr 0, data 0xFFFF → grant consumed, rf_we stays 0 that cycle.
- Assert rst_n=0 during DRAIN with 2 entries queued → rf_we=0, pipe_stall=0, mdu_ready=1 immediately. No queued write appears after release.
